// File: rtl/rv_multicycle_ctrl.sv
// Control sequencer for a multicycle RV32I-subset datapath (ADD/SUB/AND/OR/ADDI/LW/SW/BEQ).
// Latency: 4 cycles for R/ADDI/SW, 5 for LW, 3 for BEQ, 2 for an illegal encoding; outputs are combinational.
// Backpressure: mem_ready low in FETCH or MEM holds the state and mem_req for one more cycle.
module rv_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        aluout_write,
  output logic [1:0]  alu_op,
  output logic        alu_src2,
  output logic [1:0]  imm_sel,
  output logic        rf_write,
  output logic        rf_data_sel,
  output logic        pc_write,
  output logic        pc_src,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STOR = 7'b0100011;
  localparam logic [6:0] OPC_BR   = 7'b1100011;

  state_t      state;
  logic [31:0] instret_q;
  logic        retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  // Register and immediate fields belong to the datapath; only the class matters here.
  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  logic is_add, is_sub, is_and, is_or, is_rtype, is_addi, is_lw, is_sw, is_beq, is_legal;

  // Exact-encoding classification; anything else (including M-extension funct7) is illegal.
  always_comb begin
    is_add   = (opcode == OPC_R)    && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    is_sub   = (opcode == OPC_R)    && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    is_and   = (opcode == OPC_R)    && (funct3 == 3'b111) && (funct7 == 7'b0000000);
    is_or    = (opcode == OPC_R)    && (funct3 == 3'b110) && (funct7 == 7'b0000000);
    is_rtype = is_add || is_sub || is_and || is_or;
    is_addi  = (opcode == OPC_IMM)  && (funct3 == 3'b000);
    is_lw    = (opcode == OPC_LOAD) && (funct3 == 3'b010);
    is_sw    = (opcode == OPC_STOR) && (funct3 == 3'b010);
    is_beq   = (opcode == OPC_BR)   && (funct3 == 3'b000);
    is_legal = is_rtype || is_addi || is_lw || is_sw || is_beq;
  end

  // Per-state datapath controls; everything is held at 0 while rst is high.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    aluout_write = 1'b0;
    alu_op       = ALU_ADD;
    alu_src2     = 1'b0;
    imm_sel      = IMM_I;
    rf_write     = 1'b0;
    rf_data_sel  = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    illegal      = 1'b0;
    retire       = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        S_DECODE: begin
          if (!is_legal) begin
            pc_write = 1'b1;
            illegal  = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_rtype) begin
            aluout_write = 1'b1;
            if (is_sub)      alu_op = ALU_SUB;
            else if (is_and) alu_op = ALU_AND;
            else if (is_or)  alu_op = ALU_OR;
            else             alu_op = ALU_ADD;
          end else if (is_addi || is_lw || is_sw) begin
            aluout_write = 1'b1;
            alu_src2     = 1'b1;
            imm_sel      = is_sw ? IMM_S : IMM_I;
          end else if (is_beq) begin
            imm_sel  = IMM_B;
            pc_write = 1'b1;
            pc_src   = zero;
            retire   = 1'b1;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = is_sw;
          if (mem_ready) begin
            if (is_sw) begin
              pc_write = 1'b1;
              retire   = 1'b1;
            end else begin
              mdr_write = 1'b1;
            end
          end
        end
        S_WB: begin
          rf_write    = 1'b1;
          rf_data_sel = is_lw;
          pc_write    = 1'b1;
          retire      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State sequencing and retired-instruction counter (wraps naturally at 2^32).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: state <= is_legal ? S_EXEC : S_FETCH;
        S_EXEC: begin
          if (is_rtype || is_addi)  state <= S_WB;
          else if (is_lw || is_sw)  state <= S_MEM;
          else                      state <= S_FETCH;
        end
        S_MEM:    if (mem_ready) state <= is_sw ? S_FETCH : S_WB;
        S_WB:     state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: per-cycle control vectors against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// The memory handshake is exercised through mem_ready stalls in FETCH and MEM.
module tb_rv_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, aluout_write;
  logic [1:0]  alu_op, imm_sel;
  logic        alu_src2, rf_write, rf_data_sel, pc_write, pc_src, illegal;
  logic [31:0] instret;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rv_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .mdr_write(mdr_write), .aluout_write(aluout_write),
    .alu_op(alu_op), .alu_src2(alu_src2), .imm_sel(imm_sel),
    .rf_write(rf_write), .rf_data_sel(rf_data_sel), .pc_write(pc_write),
    .pc_src(pc_src), .illegal(illegal), .instret(instret)
  );

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_OR    = 32'h0020E1B3;
  localparam logic [31:0] I_AND   = 32'h0020F1B3;
  localparam logic [31:0] I_ADDI  = 32'h00808193;
  localparam logic [31:0] I_LW    = 32'h0080A283;
  localparam logic [31:0] I_SW    = 32'h0050A223;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;
  localparam logic [31:0] I_MUL   = 32'h022081B3;

  // Bit order: req we asel irw mdrw aluw op[1:0] src2 imm[1:0] rfw rfsel pcw pcsrc ill
  logic [16:0] ctl;
  assign ctl = {mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, aluout_write,
                alu_op, alu_src2, imm_sel, rf_write, rf_data_sel, pc_write, pc_src, illegal};

  function automatic logic [16:0] mk(logic req, logic we, logic asel, logic irw, logic mdrw,
                                      logic aluw, logic [1:0] op, logic src2, logic [1:0] imm,
                                      logic rfw, logic rfsel, logic pcw, logic pcsrc, logic ill);
    return {req, we, asel, irw, mdrw, aluw, op, src2, imm, rfw, rfsel, pcw, pcsrc, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Drive mem_ready for the current cycle, check controls, then advance one clock.
  task automatic step(input string tag, input logic rdy, input logic [16:0] exp);
    mem_ready = rdy;
    #1;
    check(tag, {15'd0, ctl}, {15'd0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [16:0] C_ZERO, C_FETCH, C_FETCH_WAIT, C_DEC, C_WB_ALU, C_WB_LW;
  logic [31:0] rt_instr [4];
  logic [1:0]  rt_op    [4];

  initial begin
    C_ZERO       = '0;
    C_FETCH      = mk(1,0,0,1,0,0,2'd0,0,2'd0,0,0,0,0,0);
    C_FETCH_WAIT = mk(1,0,0,0,0,0,2'd0,0,2'd0,0,0,0,0,0);
    C_DEC        = '0;
    C_WB_ALU     = mk(0,0,0,0,0,0,2'd0,0,2'd0,1,0,1,0,0);
    C_WB_LW      = mk(0,0,0,0,0,0,2'd0,0,2'd0,1,1,1,0,0);
    rt_instr[0] = I_ADD; rt_op[0] = 2'd0;
    rt_instr[1] = I_SUB; rt_op[1] = 2'd1;
    rt_instr[2] = I_AND; rt_op[2] = 2'd2;
    rt_instr[3] = I_OR;  rt_op[3] = 2'd3;

    rst = 1'b1; instr = I_ADD; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    check("rst_outputs", {15'd0, ctl}, 32'd0);
    check("rst_instret", instret, 32'd0);
    rst = 1'b0;
    #0;

    // ADD, zero-wait: 4 cycles, one retirement.
    instr = I_ADD;
    step("add_fetch", 1, C_FETCH);
    step("add_decode", 1, C_DEC);
    step("add_exec", 1, mk(0,0,0,0,0,1,2'd0,0,2'd0,0,0,0,0,0));
    step("add_wb", 1, C_WB_ALU);
    check("add_instret", instret, 32'd1);

    // Remaining R-type functions and ADDI: check EXEC encoding per instruction.
    for (int i = 1; i < 4; i++) begin
      instr = rt_instr[i];
      step("rt_fetch", 1, C_FETCH);
      step("rt_decode", 1, C_DEC);
      step("rt_exec", 1, mk(0,0,0,0,0,1,rt_op[i],0,2'd0,0,0,0,0,0));
      step("rt_wb", 1, C_WB_ALU);
    end
    check("rt_instret", instret, 32'd4);

    instr = I_ADDI;
    step("addi_fetch", 1, C_FETCH);
    step("addi_decode", 1, C_DEC);
    step("addi_exec", 1, mk(0,0,0,0,0,1,2'd0,1,2'd0,0,0,0,0,0));
    step("addi_wb", 1, C_WB_ALU);
    check("addi_instret", instret, 32'd5);

    // LW with one FETCH stall and two MEM stalls: 8 cycles.
    instr = I_LW;
    step("lw_fetch_wait", 0, C_FETCH_WAIT);
    step("lw_fetch", 1, C_FETCH);
    step("lw_decode", 1, C_DEC);
    step("lw_exec", 1, mk(0,0,0,0,0,1,2'd0,1,2'd0,0,0,0,0,0));
    step("lw_mem_wait0", 0, mk(1,0,1,0,0,0,2'd0,0,2'd0,0,0,0,0,0));
    step("lw_mem_wait1", 0, mk(1,0,1,0,0,0,2'd0,0,2'd0,0,0,0,0,0));
    check("lw_instret_mid", instret, 32'd5);
    step("lw_mem_done", 1, mk(1,0,1,0,1,0,2'd0,0,2'd0,0,0,0,0,0));
    step("lw_wb", 1, C_WB_LW);
    check("lw_instret", instret, 32'd6);

    // SW zero-wait: 4 cycles, retires from MEM.
    instr = I_SW;
    step("sw_fetch", 1, C_FETCH);
    step("sw_decode", 1, C_DEC);
    step("sw_exec", 1, mk(0,0,0,0,0,1,2'd0,1,2'd1,0,0,0,0,0));
    step("sw_mem", 1, mk(1,1,1,0,0,0,2'd0,0,2'd0,0,0,1,0,0));
    check("sw_instret", instret, 32'd7);

    // BEQ taken then not taken: 3 cycles each.
    instr = I_BEQ; zero = 1'b1;
    step("beq1_fetch", 1, C_FETCH);
    step("beq1_decode", 1, C_DEC);
    step("beq1_exec", 1, mk(0,0,0,0,0,0,2'd0,0,2'd2,0,0,1,1,0));
    zero = 1'b0;
    step("beq0_fetch", 1, C_FETCH);
    zero = 1'b1;
    step("beq0_decode", 1, C_DEC);
    zero = 1'b0;
    step("beq0_exec", 1, mk(0,0,0,0,0,0,2'd0,0,2'd2,0,0,1,0,0));
    check("beq_instret", instret, 32'd9);

    // Illegal encodings: 2 cycles, no retirement.
    instr = I_ILL;
    step("ill_fetch", 1, C_FETCH);
    step("ill_decode", 1, mk(0,0,0,0,0,0,2'd0,0,2'd0,0,0,1,0,1));
    instr = I_MUL;
    step("mul_fetch", 1, C_FETCH);
    step("mul_decode", 1, mk(0,0,0,0,0,0,2'd0,0,2'd0,0,0,1,0,1));
    check("ill_instret", instret, 32'd9);

    // Reset during a stalled SW access.
    instr = I_SW;
    step("rsw_fetch", 1, C_FETCH);
    step("rsw_decode", 1, C_DEC);
    step("rsw_exec", 1, mk(0,0,0,0,0,1,2'd0,1,2'd1,0,0,0,0,0));
    mem_ready = 1'b0;
    #1;
    check("rsw_mem_wait", {15'd0, ctl}, {15'd0, mk(1,1,1,0,0,0,2'd0,0,2'd0,0,0,0,0,0)});
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rsw_rst_outputs", {15'd0, ctl}, 32'd0);
    @(posedge clk); #1;
    check("rsw_rst_hold", {15'd0, ctl}, 32'd0);
    check("rsw_rst_instret", instret, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step("rsw_release_fetch", 0, C_FETCH_WAIT);
    check("rsw_instret_after", instret, 32'd0);

    // Counter wrap: preset the count to all ones and retire an ADD.
    force dut.instret_q = 32'hFFFFFFFF;
    #1;
    release dut.instret_q;
    instr = I_ADD;
    step("wrap_fetch", 1, C_FETCH);
    step("wrap_decode", 1, C_DEC);
    step("wrap_exec", 1, mk(0,0,0,0,0,1,2'd0,0,2'd0,0,0,0,0,0));
    check("wrap_instret_pre", instret, 32'hFFFFFFFF);
    step("wrap_wb", 1, C_WB_ALU);
    check("wrap_instret", instret, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Control FSM that sequences a multicycle RV32I-subset datapath: a single memory port shared by instruction fetch and load/store, an instruction register (IR), a memory data register (MDR), an ALU-output register, and the PC. It issues all datapath enables and selects per state. It handles a variable-latency memory handshake and counts retired instructions. The supported subset is ADD, SUB, AND, OR, ADDI, LW, SW and BEQ; every other encoding retires as a flagged NOP.

## Interface
Parameters:
- none (encodings fixed: alu_op ADD=0, SUB=1, AND=2, OR=3; imm_sel I=0, S=1, B=2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  IR output; stable from DECODE until next FETCH
- zero  in  1  ALU equality flag (alu_in1 == alu_in2)
- mem_ready  in  1  memory completes access in any cycle it is high with mem_req high
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe (valid with mem_req)
- mem_addr_sel  out  1  0 = PC, 1 = ALU-output register
- ir_write  out  1  load IR from memory read data
- mdr_write  out  1  load MDR from memory read data
- aluout_write  out  1  load ALU-output register
- alu_op  out  2  ALU function
- alu_src2  out  1  0 = rs2, 1 = immediate
- imm_sel  out  2  immediate format
- rf_write  out  1  register-file write (rd==0 suppression is in the RF)
- rf_data_sel  out  1  0 = ALU-output register, 1 = MDR
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC+4, 1 = PC+imm (B)
- illegal  out  1  one-cycle pulse on an unsupported instruction
- instret  out  32  count of retired legal instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. All outputs are combinational from the state and from instr. Any output not listed for a state is 0.
- FETCH: mem_req=1, mem_addr_sel=0.
  - mem_ready=1: ir_write=1, then DECODE.
  - Otherwise: stay in FETCH with mem_req held.
- DECODE: classify instr by opcode/funct3/funct7 (exact RV32I encodings).
  - Legal: go to EXEC.
  - Illegal: pc_write=1, pc_src=0, illegal=1, then FETCH. instret is not incremented.
- EXEC:
  - R-type: alu_src2=0, alu_op from funct; aluout_write=1, then WB.
  - ADDI: alu_op=ADD, alu_src2=1, imm_sel=I, aluout_write=1, then WB.
  - LW / SW: alu_op=ADD, alu_src2=1, imm_sel=I (LW) or S (SW), aluout_write=1, then MEM.
  - BEQ: alu_src2=0, imm_sel=B, pc_write=1, pc_src=zero; retire, then FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for SW.
  - mem_ready=0: stay in MEM with outputs held.
  - mem_ready=1 and SW: pc_write=1, pc_src=0; retire, then FETCH.
  - mem_ready=1 and LW: mdr_write=1, then WB.
- WB: rf_write=1, rf_data_sel=1 for LW and 0 otherwise; pc_write=1, pc_src=0; retire, then FETCH.
- Retire: instret increments by 1 and wraps modulo 2^32 (0xFFFFFFFF -> 0).
- Only one of ir_write / mdr_write / aluout_write / rf_write / pc_write may be high in a given cycle, except where listed above. No combination beyond those listed is legal.

## Timing
- Reset:
  - Sampled at the clock edge: state <= FETCH, instret <= 0.
  - While rst is high, all outputs are forced to 0, including mem_req.
  - Reset mid-access abandons the access; no write enable fires after the reset cycle.
- First cycle after rst deasserts: mem_req=1, fetching the PC.
- Latency with zero-wait memory (mem_ready tied high), in cycles including FETCH:
  - R-type / ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - illegal: 2
- Each cycle of mem_ready=0 in FETCH or MEM adds exactly one cycle. mem_req is never deasserted while an access is pending.
- instret updates at the clock edge that ends the retiring state. The new value is visible the following cycle.
- zero is sampled only in EXEC of BEQ; its value in other states is ignored.

## Test plan
- Reset, then mem_ready=1, instr=ADD x3,x1,x2 (0x002081B3) -> FETCH, DECODE, EXEC (alu_op=0, aluout_write), WB (rf_write, rf_data_sel=0, pc_write, pc_src=0); instret=1 after 4 cycles.
- LW x5,8(x1) (0x0080A283) with mem_ready low for 2 cycles in MEM -> mem_req/mem_addr_sel=1 held 3 cycles, mdr_write in the ready cycle, WB with rf_data_sel=1; total 7 cycles.
- SW x5,4(x1) (0x0050A223) -> MEM with mem_we=1, imm_sel=S, no rf_write; 4 cycles.
- BEQ with zero=1 then zero=0 (0x00208463) -> pc_src=1 then pc_src=0 in EXEC; 3 cycles each; instret +2.
- instr=0xFFFFFFFF -> illegal pulse in DECODE, pc_write with pc_src=0, instret unchanged, back in FETCH after 2 cycles.
- rst raised during MEM of SW while mem_ready=0 -> all outputs 0, no mem_we after reset, FETCH on release, instret=0. Separately: preload 0xFFFFFFFF retirements, or force 0xFFFFFFFF and retire ADD -> instret=0.
